rcc_reset_sequencer: RTL and testbench
======================================

// Module: rcc_reset_sequencer
// PURPOSE
//  Sequences the reset/clock-control outputs of the RCC block. Stages PRESETn and WDOGRESn release after HRESETn.
//  Issues software peripheral-reset pulses and system-reset requests (software or watchdog).
//  Controls the PCLKG gate enable from APB_ACTIVE and latches a sticky reset-cause record.
//  Sits between the AHB-facing RCC register front end and the clock/reset outputs.
// PARAMETERS
//  CNT_W      8   width of the shared delay/pulse counter
//  PRST_DLY   4   HCLK cycles from reset release to PRESETn release (1..2^CNT_W-1)
//  WDOG_DLY   8   HCLK cycles from PRESETn release to WDOGRESn release (1..2^CNT_W-1)
//  PULSE_LEN  4   width in HCLK cycles of software/system reset pulses (1..2^CNT_W-1)
//  IDLE_HOLD  8   cycles PCLK_EN stays high after APB_ACTIVE falls (hysteresis build only)
// PORTS
//  HCLK          in   1  system clock
//  HRESETn       in   1  async active-low reset
//  PRST_REQ      in   1  1-cycle pulse: software peripheral reset request
//  SYSRESETREQ   in   1  1-cycle pulse: software system reset request
//  WDOG_RST_REQ  in   1  1-cycle pulse: watchdog reset request
//  APB_ACTIVE    in   1  APB transfer pending/active
//  CAUSE_CLR     in   1  1-cycle pulse: clear RST_CAUSE
//  PRESETn       out  1  APB peripheral reset, active low
//  WDOGRESn      out  1  watchdog reset, active low
//  HRESET_REQ    out  1  request to system reset generator, active high
//  PCLK_EN       out  1  PCLKG gate enable
//  SEQ_BUSY      out  1  high in every state except RUN
//  RST_CAUSE     out  3  sticky cause: [0] POR/ext, [1] SYSRESETREQ, [2] watchdog
// BEHAVIOUR
//  - All outputs are registered. Reset values: PRESETn=0, WDOGRESn=0, HRESET_REQ=0, PCLK_EN=1, SEQ_BUSY=1,
//    RST_CAUSE=3'b001. FSM=P_WAIT, counter=0.
//  - FSM states: P_WAIT, W_WAIT, RUN, P_PULSE, S_PULSE.
//  - P_WAIT: counter counts up. PRESETn goes 1 on the PRST_DLY-th rising edge after HRESETn deasserts; the
//    counter clears and the FSM enters W_WAIT.
//  - W_WAIT: WDOGRESn goes 1 WDOG_DLY edges after PRESETn rises; the FSM enters RUN and SEQ_BUSY drops on
//    the same edge.
//  - RUN: request priority is WDOG_RST_REQ > SYSRESETREQ > PRST_REQ; one request is accepted per edge.
//  - PRST_REQ in RUN: next edge PRESETn=0 and the FSM enters P_PULSE. After PULSE_LEN cycles low, PRESETn=1
//    and the FSM returns to RUN. WDOGRESn is unaffected.
//  - SYSRESETREQ or WDOG_RST_REQ in RUN or P_PULSE: next edge PRESETn=0, WDOGRESn=0, HRESET_REQ=1, and the
//    FSM enters S_PULSE, which preempts P_PULSE. The matching RST_CAUSE bit sets.
//  - S_PULSE: after PULSE_LEN cycles HRESET_REQ=0, counter clears, FSM enters P_WAIT and re-runs the full
//    release sequence.
//  - Ignored requests (no effect, not queued):
//    - any request in P_WAIT, W_WAIT or S_PULSE;
//    - PRST_REQ in P_PULSE.
//  - RST_CAUSE:
//    - CAUSE_CLR zeroes all bits;
//    - a cause set and CAUSE_CLR on the same edge leave only the new bit set;
//    - bit0 is set only by HRESETn.
//  - PCLK_EN is forced 1 in every state except RUN, so resets reach gated peripherals.
//  - Counter compares are at full CNT_W width. The counter saturates and never wraps. It clears on every
//    state change.
//  - HRESETn asserted mid-sequence or mid-pulse returns all state to reset values asynchronously. Any
//    in-flight pulse is abandoned.
// CONFIGURATION
//  - RCC_SEQ_GATE_HYST_EN defined: in RUN, PCLK_EN=1 the edge after APB_ACTIVE=1. After APB_ACTIVE falls,
//    PCLK_EN holds 1 for IDLE_HOLD further cycles, then drops. APB_ACTIVE reasserting during the hold
//    reloads the hold count with no PCLK_EN glitch.
//  - Not defined: in RUN, PCLK_EN is APB_ACTIVE registered once (1-cycle latency). IDLE_HOLD is unused.
// TESTING
//  1. Release HRESETn (defaults) -> PRESETn rises at edge 4, WDOGRESn at edge 12, SEQ_BUSY=0 at edge 12,
//     RST_CAUSE=3'b001.
//  2. In RUN, PRST_REQ pulse -> PRESETn low exactly 4 cycles, WDOGRESn stays 1, FSM back to RUN.
//  3. In RUN, assert WDOG_RST_REQ and SYSRESETREQ on the same edge -> HRESET_REQ high 4 cycles,
//     RST_CAUSE[2]=1, RST_CAUSE[1]=0, then full release sequence (4+8 cycles).
//  4. SYSRESETREQ 2 cycles into a P_PULSE -> S_PULSE entered next edge, RST_CAUSE[1]=1. PRST_REQ during
//     P_WAIT is ignored.
//  5. CAUSE_CLR on the same edge a watchdog request is accepted -> RST_CAUSE=3'b100.
//  6. With RCC_SEQ_GATE_HYST_EN, drop APB_ACTIVE then re-raise after 5 cycles -> PCLK_EN never falls. With
//     the line left low, PCLK_EN falls exactly 8 cycles after the drop. Assert HRESETn mid-hold -> all
//     outputs at reset values immediately.

Source files
------------

// File: rtl/rcc_reset_sequencer.sv
// rtl/rcc_reset_sequencer.sv - RCC reset release sequencer, reset pulses, PCLKG gate and sticky reset cause
// Define RCC_SEQ_GATE_HYST_EN to hold PCLK_EN high for IDLE_HOLD cycles after APB_ACTIVE falls.
module rcc_reset_sequencer #(
  parameter int CNT_W     = 8,
  parameter int PRST_DLY  = 4,
  parameter int WDOG_DLY  = 8,
  parameter int PULSE_LEN = 4,
  parameter int IDLE_HOLD = 8
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       PRST_REQ,
  input  logic       SYSRESETREQ,
  input  logic       WDOG_RST_REQ,
  input  logic       APB_ACTIVE,
  input  logic       CAUSE_CLR,
  output logic       PRESETn,
  output logic       WDOGRESn,
  output logic       HRESET_REQ,
  output logic       PCLK_EN,
  output logic       SEQ_BUSY,
  output logic [2:0] RST_CAUSE
);

  typedef enum logic [2:0] {
    P_WAIT  = 3'd0,
    W_WAIT  = 3'd1,
    RUN     = 3'd2,
    P_PULSE = 3'd3,
    S_PULSE = 3'd4
  } state_t;

  // The counter starts at 0 on entry, so the last cycle of a stage is at DLY-1.
  localparam logic [CNT_W-1:0] PRST_LAST  = CNT_W'(PRST_DLY - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_DLY - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  if (CNT_W < 1 || PRST_DLY < 1 || PRST_DLY >= 2**CNT_W || WDOG_DLY < 1 || WDOG_DLY >= 2**CNT_W ||
      PULSE_LEN < 1 || PULSE_LEN >= 2**CNT_W || IDLE_HOLD < 1) begin : g_param_check
    $error("rcc_reset_sequencer: parameter out of range");
  end

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       cause_set, rst_cause_d;
  logic             presetn_d, wdogresn_d, hreset_req_d, pclk_en_d, seq_busy_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= P_WAIT;
      cnt        <= '0;
      PRESETn    <= 1'b0;
      WDOGRESn   <= 1'b0;
      HRESET_REQ <= 1'b0;
      PCLK_EN    <= 1'b1;
      SEQ_BUSY   <= 1'b1;
      RST_CAUSE  <= 3'b001;
    end else begin
      state      <= next_state;
      cnt        <= cnt_d;
      PRESETn    <= presetn_d;
      WDOGRESn   <= wdogresn_d;
      HRESET_REQ <= hreset_req_d;
      PCLK_EN    <= pclk_en_d;
      SEQ_BUSY   <= seq_busy_d;
      RST_CAUSE  <= rst_cause_d;
    end
  end

  // Watchdog outranks a software system reset, which outranks a peripheral reset.
  always_comb begin
    next_state = state;
    cause_set  = 3'b000;
    case (state)
      P_WAIT:  if (cnt == PRST_LAST) next_state = W_WAIT;
      W_WAIT:  if (cnt == WDOG_LAST) next_state = RUN;
      RUN: begin
        if (WDOG_RST_REQ) begin
          next_state = S_PULSE;
          cause_set  = 3'b100;
        end else if (SYSRESETREQ) begin
          next_state = S_PULSE;
          cause_set  = 3'b010;
        end else if (PRST_REQ) begin
          next_state = P_PULSE;
        end
      end
      P_PULSE: begin
        if (WDOG_RST_REQ) begin
          next_state = S_PULSE;
          cause_set  = 3'b100;
        end else if (SYSRESETREQ) begin
          next_state = S_PULSE;
          cause_set  = 3'b010;
        end else if (cnt == PULSE_LAST) begin
          next_state = RUN;
        end
      end
      S_PULSE: if (cnt == PULSE_LAST) next_state = P_WAIT;
      default: next_state = P_WAIT;
    endcase
  end

`ifdef RCC_SEQ_GATE_HYST_EN
  localparam int HOLD_W = $clog2(IDLE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(IDLE_HOLD);

  logic [HOLD_W-1:0] hold, hold_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hold <= HOLD_INIT;
    else          hold <= hold_d;
  end
`endif

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    presetn_d    = (next_state == W_WAIT) || (next_state == RUN);
    wdogresn_d   = (next_state == RUN) || (next_state == P_PULSE);
    hreset_req_d = (next_state == S_PULSE);
    seq_busy_d   = (next_state != RUN);
    rst_cause_d  = (CAUSE_CLR ? 3'b000 : RST_CAUSE) | cause_set;
    if (next_state != state) cnt_d = '0;
    else if (cnt == '1)      cnt_d = cnt;
    else                     cnt_d = cnt + 1'b1;
`ifdef RCC_SEQ_GATE_HYST_EN
    hold_d = hold;
    if (next_state != RUN || APB_ACTIVE) begin
      hold_d    = HOLD_INIT;
      pclk_en_d = 1'b1;
    end else if (hold != '0) begin
      hold_d    = hold - 1'b1;
      pclk_en_d = 1'b1;
    end else begin
      pclk_en_d = 1'b0;
    end
`else
    pclk_en_d = (next_state != RUN) || APB_ACTIVE;
`endif
  end

endmodule

// File: tb/tb_rcc_reset_sequencer.sv
// tb/tb_rcc_reset_sequencer.sv - self-checking bench for rcc_reset_sequencer
module tb_rcc_reset_sequencer;

  localparam int CNT_W     = 8;
  localparam int PRST_DLY  = 4;
  localparam int WDOG_DLY  = 8;
  localparam int PULSE_LEN = 4;
  localparam int IDLE_HOLD = 8;
`ifdef RCC_SEQ_GATE_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic       HCLK, HRESETn;
  logic       PRST_REQ, SYSRESETREQ, WDOG_RST_REQ, APB_ACTIVE, CAUSE_CLR;
  logic       PRESETn, WDOGRESn, HRESET_REQ, PCLK_EN, SEQ_BUSY;
  logic [2:0] RST_CAUSE;

  rcc_reset_sequencer #(
    .CNT_W(CNT_W), .PRST_DLY(PRST_DLY), .WDOG_DLY(WDOG_DLY),
    .PULSE_LEN(PULSE_LEN), .IDLE_HOLD(IDLE_HOLD)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PRST_REQ(PRST_REQ), .SYSRESETREQ(SYSRESETREQ),
    .WDOG_RST_REQ(WDOG_RST_REQ), .APB_ACTIVE(APB_ACTIVE), .CAUSE_CLR(CAUSE_CLR),
    .PRESETn(PRESETn), .WDOGRESn(WDOGRESn), .HRESET_REQ(HRESET_REQ), .PCLK_EN(PCLK_EN),
    .SEQ_BUSY(SEQ_BUSY), .RST_CAUSE(RST_CAUSE)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Timeline model: n counts edges since the last reset release; the release sequence
  // started at rel_start, a system pulse covers edges before s_end, a peripheral pulse before p_end.
  int         n, rel_start, s_end, p_end, last_hi;
  logic [2:0] m_cause;
  logic       m_pclk;

  function automatic bit in_s(int t);
    return t < s_end;
  endfunction
  function automatic bit in_p(int t);
    return t < p_end;
  endfunction
  function automatic bit in_run(int t);
    return !in_s(t) && !in_p(t) && (t >= rel_start + PRST_DLY + WDOG_DLY);
  endfunction

  task automatic m_reset();
    n = 0; rel_start = 0; s_end = 0; p_end = 0; last_hi = 0;
    m_cause = 3'b001; m_pclk = 1'b1;
  endtask

  task automatic m_step();
    int t;
    bit run_prev, pp_prev;
    logic [2:0] newc;
    run_prev = in_run(n);
    pp_prev  = in_p(n) && !in_s(n);
    t = n + 1;
    newc = 3'b000;
    if ((run_prev || pp_prev) && (WDOG_RST_REQ || SYSRESETREQ)) begin
      s_end = t + PULSE_LEN;
      rel_start = t + PULSE_LEN;
      p_end = 0;
      newc = WDOG_RST_REQ ? 3'b100 : 3'b010;
    end else if (run_prev && PRST_REQ) begin
      p_end = t + PULSE_LEN;
    end
    m_cause = (CAUSE_CLR ? 3'b000 : m_cause) | newc;
    if (!in_run(t)) begin
      last_hi = t;
      m_pclk = 1'b1;
    end else if (HYST) begin
      if (APB_ACTIVE) last_hi = t;
      m_pclk = (t - last_hi) <= IDLE_HOLD;
    end else begin
      m_pclk = APB_ACTIVE;
    end
    n = t;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge HCLK);
      if (cmp_en) begin
        chk("cyc_presetn", PRESETn, !in_s(n) && !in_p(n) && (n >= rel_start + PRST_DLY));
        chk("cyc_wdogresn", WDOGRESn, !in_s(n) && (n >= rel_start + PRST_DLY + WDOG_DLY));
        chk("cyc_hreset_req", HRESET_REQ, in_s(n));
        chk("cyc_seq_busy", SEQ_BUSY, !in_run(n));
        chk("cyc_pclk_en", PCLK_EN, m_pclk);
        chk("cyc_rst_cause", RST_CAUSE, m_cause);
      end
    end
  end

  task automatic wait_run(output int k);
    k = 0;
    while (SEQ_BUSY !== 1'b0 && k < 100) begin
      @(negedge HCLK);
      k++;
    end
  endtask

  task automatic count_while(input bit use_hreq, output int k);
    k = 0;
    while (((use_hreq ? HRESET_REQ : !PRESETn) === 1'b1) && k < 40) begin
      k++;
      @(negedge HCLK);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_presetn"}, PRESETn, 1'b0);
    chk({tag, "_wdogresn"}, WDOGRESn, 1'b0);
    chk({tag, "_hreset_req"}, HRESET_REQ, 1'b0);
    chk({tag, "_pclk_en"}, PCLK_EN, 1'b1);
    chk({tag, "_seq_busy"}, SEQ_BUSY, 1'b1);
    chk({tag, "_rst_cause"}, RST_CAUSE, 3'b001);
  endtask

  int k;

  initial begin
    HRESETn = 1'b1;
    PRST_REQ = 1'b0; SYSRESETREQ = 1'b0; WDOG_RST_REQ = 1'b0; CAUSE_CLR = 1'b0;
    APB_ACTIVE = 1'b1;
    #2 HRESETn = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge HCLK);
    check_reset_outputs("por");

    // Release: PRESETn at edge 4, WDOGRESn and SEQ_BUSY at edge 12.
    HRESETn = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge HCLK);
      if (e == 3)  chk("rel_presetn_e3", PRESETn, 1'b0);
      if (e == 4)  chk("rel_presetn_e4", PRESETn, 1'b1);
      if (e == 11) chk("rel_wdogresn_e11", WDOGRESn, 1'b0);
      if (e == 11) chk("rel_busy_e11", SEQ_BUSY, 1'b1);
      if (e == 12) chk("rel_wdogresn_e12", WDOGRESn, 1'b1);
      if (e == 12) chk("rel_busy_e12", SEQ_BUSY, 1'b0);
      if (e == 12) chk("rel_cause", RST_CAUSE, 3'b001);
    end

    // Peripheral reset pulse.
    @(negedge HCLK);
    PRST_REQ = 1'b1;
    @(negedge HCLK);
    PRST_REQ = 1'b0;
    chk("ppulse_wdogresn", WDOGRESn, 1'b1);
    count_while(1'b0, k);
    chk("ppulse_len", k, PULSE_LEN);
    chk("ppulse_back_run", SEQ_BUSY, 1'b0);

    // Simultaneous watchdog and system requests: watchdog wins.
    WDOG_RST_REQ = 1'b1; SYSRESETREQ = 1'b1;
    @(negedge HCLK);
    WDOG_RST_REQ = 1'b0; SYSRESETREQ = 1'b0;
    chk("spulse_cause", RST_CAUSE, 3'b101);
    chk("spulse_presetn", PRESETn, 1'b0);
    count_while(1'b1, k);
    chk("spulse_len", k, PULSE_LEN);
    wait_run(k);
    chk("spulse_rerelease", k, PRST_DLY + WDOG_DLY);

    // System request two cycles into a peripheral pulse preempts it.
    PRST_REQ = 1'b1;
    @(negedge HCLK);
    PRST_REQ = 1'b0;
    @(negedge HCLK);
    SYSRESETREQ = 1'b1;
    @(negedge HCLK);
    SYSRESETREQ = 1'b0;
    chk("preempt_hreq", HRESET_REQ, 1'b1);
    chk("preempt_cause", RST_CAUSE, 3'b111);
    chk("preempt_wdogresn", WDOGRESn, 1'b0);
    count_while(1'b1, k);
    // PRST_REQ in P_WAIT must not disturb the release timing.
    PRST_REQ = 1'b1;
    k = 0;
    do begin
      @(negedge HCLK);
      PRST_REQ = 1'b0;
      k++;
    end while (SEQ_BUSY === 1'b1 && k < 100);
    chk("pwait_ignore_release", k, PRST_DLY + WDOG_DLY);

    // CAUSE_CLR with a watchdog acceptance on the same edge.
    CAUSE_CLR = 1'b1; WDOG_RST_REQ = 1'b1;
    @(negedge HCLK);
    CAUSE_CLR = 1'b0; WDOG_RST_REQ = 1'b0;
    chk("clr_wdog_cause", RST_CAUSE, 3'b100);
    count_while(1'b1, k);
    repeat (6) @(negedge HCLK);
    SYSRESETREQ = 1'b1;
    @(negedge HCLK);
    SYSRESETREQ = 1'b0;
    chk("wwait_ignore_hreq", HRESET_REQ, 1'b0);
    chk("wwait_ignore_cause", RST_CAUSE, 3'b100);
    wait_run(k);
    chk("wwait_ignore_release", k, 5);
    CAUSE_CLR = 1'b1;
    @(negedge HCLK);
    CAUSE_CLR = 1'b0;
    chk("clr_only_cause", RST_CAUSE, 3'b000);

    // PCLK gating in RUN.
    chk("gate_active", PCLK_EN, 1'b1);
    APB_ACTIVE = 1'b0;
    for (int i = 1; i <= IDLE_HOLD + 2; i++) begin
      @(negedge HCLK);
      chk("gate_fall", PCLK_EN, (i >= (HYST ? IDLE_HOLD + 1 : 1)) ? 1'b0 : 1'b1);
    end
    APB_ACTIVE = 1'b1;
    @(negedge HCLK);
    chk("gate_rise", PCLK_EN, 1'b1);
    APB_ACTIVE = 1'b0;
    repeat (5) @(negedge HCLK);
    APB_ACTIVE = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("gate_reraise", PCLK_EN, 1'b1);

    // Asynchronous reset in the middle of an idle hold.
    APB_ACTIVE = 1'b0;
    repeat (3) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge HCLK);
    HRESETn = 1'b1;
    wait_run(k);
    chk("async_rerelease", k, PRST_DLY + WDOG_DLY);
    repeat (3) @(negedge HCLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
